// File: rtl/mem_dbus_ctrl_if.sv
// Data-memory request bus between the M-stage controller (master) and the memory side (slave).
// Handshake: req/addr_ok accepts a request; data_ok later completes it.
interface mem_dbus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/mem_dbus_ctrl.sv
// M-stage data bus controller: issues one word load/store per instruction, stalls the
// pipeline until completion, and absorbs responses orphaned by a flush.
module mem_dbus_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [DATA_W-1:0] writedataM,
    input  logic              flushM,
    input  logic              holdM,
    mem_dbus_ctrl_if.master   dbus,
    output logic [DATA_W-1:0] readdataM,
    output logic              stallM,
    output logic              addr_errM
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic op, unal, go;
    logic st_idle, st_req, st_wait, st_drain;

    assign op   = MemtoRegM | MemWriteM;
    assign unal = |aluoutM[1:0];
    assign go   = op & ~unal & ~flushM;

    assign st_idle  = (state_q == S_IDLE);
    assign st_req   = (state_q == S_REQ);
    assign st_wait  = (state_q == S_WAIT);
    assign st_drain = (state_q == S_DRAIN);

    // A flush in REQ withdraws the request in that same cycle, so an addr_ok can never
    // be granted to an instruction that is being squashed.
    assign dbus.data_req   = (st_idle & go) | (st_req & ~flushM);
    assign dbus.data_wr    = MemWriteM;
    assign dbus.data_addr  = {aluoutM[ADDR_W-1:2], 2'b00};
    assign dbus.data_wdata = writedataM;

    assign stallM    = (st_idle & go) | st_req | (st_wait & ~dbus.data_data_ok) | (st_drain & op);
    assign addr_errM = st_idle & op & unal & ~flushM;
    assign readdataM = (st_wait & dbus.data_data_ok) ? dbus.data_rdata : rdata_q;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = dbus.data_addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                if (flushM) begin
                    state_d = S_IDLE;
                end else if (dbus.data_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dbus.data_data_ok) begin
                    state_d = (flushM | ~holdM) ? S_IDLE : S_DONE;
                    if (~flushM & MemtoRegM) begin
                        rdata_d = dbus.data_rdata;
                    end
                end else if (flushM) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (~holdM | flushM) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                // The response belongs to a squashed instruction; drop its data.
                if (dbus.data_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed bench for mem_dbus_ctrl: scoreboard of expected bus requests and load results,
// plus per-cycle checks of data_req/stallM/addr_errM/readdataM.
module tb_mem_dbus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemtoRegM, MemWriteM, flushM, holdM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, addr_errM;

    mem_dbus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

    mem_dbus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemtoRegM (MemtoRegM),
        .MemWriteM (MemWriteM),
        .aluoutM   (aluoutM),
        .writedataM(writedataM),
        .flushM    (flushM),
        .holdM     (holdM),
        .dbus      (dbus),
        .readdataM (readdataM),
        .stallM    (stallM),
        .addr_errM (addr_errM)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_rd[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected request on each accepted request, and an expected load
    // result whenever a load leaves M (not stalled, not held, not squashed, aligned).
    always @(negedge clk) begin
        if (reset) begin
            if (dbus.data_req && dbus.data_addr_ok) begin
                check("req_expected", 32'(exp_req.size() != 0), 32'd1);
                if (exp_req.size() != 0) begin
                    req_t r;
                    r = exp_req.pop_front();
                    check("req_wr", 32'(dbus.data_wr), 32'(r.wr));
                    check("req_addr", dbus.data_addr, r.addr);
                    if (r.wr) check("req_wdata", dbus.data_wdata, r.wdata);
                end
            end
            if (MemtoRegM && !stallM && !holdM && !flushM && !addr_errM) begin
                check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) check("readdataM", readdataM, exp_rd.pop_front());
            end
        end
    end

    task automatic drive(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] wd, input logic fl, input logic hd);
        MemtoRegM  = ld;
        MemWriteM  = st;
        aluoutM    = addr;
        writedataM = wd;
        flushM     = fl;
        holdM      = hd;
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
        dbus.data_addr_ok = aok;
        dbus.data_data_ok = dok;
        dbus.data_rdata   = rd;
    endtask

    // One cycle: check outputs at the falling edge (-1 = don't check), then advance.
    task automatic cyc(input string tag, input int er, input int es, input int ea,
                       input int rd_en, input logic [31:0] rd_exp);
        @(negedge clk);
        if (er >= 0) check({tag, "_req"}, 32'(dbus.data_req), 32'(er));
        if (es >= 0) check({tag, "_stall"}, 32'(stallM), 32'(es));
        if (ea >= 0) check({tag, "_aerr"}, 32'(addr_errM), 32'(ea));
        if (rd_en != 0) check({tag, "_rdata"}, readdataM, rd_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        bus(0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 0, 0, 0, 1, 32'h0);
        reset = 1'b1;

        // Load, zero wait states
        exp_req.push_back('{1'b0, 32'h0000_1004, 32'h0});
        exp_rd.push_back(32'hDEAD_BEEF);
        drive(1, 0, 32'h0000_1004, 32'h0, 0, 0);
        bus(1, 0, 32'h0);
        cyc("t1_issue", 1, 1, 0, 0, 0);
        bus(0, 1, 32'hDEAD_BEEF);
        cyc("t1_data", 0, 0, 0, 1, 32'hDEAD_BEEF);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        bus(0, 0, 32'h0);
        cyc("t1_after", 0, 0, 0, 1, 32'hDEAD_BEEF);

        // Store, addr_ok delayed 3 cycles, data_ok 2 cycles after acceptance
        exp_req.push_back('{1'b1, 32'h0000_2000, 32'h1234_5678});
        drive(0, 1, 32'h0000_2000, 32'h1234_5678, 0, 0);
        cyc("t2_c1", 1, 1, 0, 0, 0);
        cyc("t2_c2", 1, 1, 0, 0, 0);
        cyc("t2_c3", 1, 1, 0, 0, 0);
        bus(1, 0, 32'h0);
        cyc("t2_acc", 1, 1, 0, 0, 0);
        bus(0, 0, 32'h0);
        cyc("t2_wait", 0, 1, 0, 0, 0);
        bus(0, 1, 32'h5555_AAAA);
        cyc("t2_data", 0, 0, 0, 1, 32'h5555_AAAA);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        bus(0, 0, 32'h0);
        cyc("t2_after", 0, 0, 0, 1, 32'hDEAD_BEEF);

        // Load withdrawn by flush while in REQ
        drive(1, 0, 32'h0000_3000, 32'h0, 0, 0);
        cyc("t3_issue", 1, 1, 0, 0, 0);
        flushM = 1'b1;
        cyc("t3_flush", 0, -1, 0, 0, 0);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        cyc("t3_idle", 0, 0, 0, 1, 32'hDEAD_BEEF);

        // Flush in WAIT -> DRAIN blocks the next load until the orphan data_ok
        exp_req.push_back('{1'b0, 32'h0000_4000, 32'h0});
        drive(1, 0, 32'h0000_4000, 32'h0, 0, 0);
        bus(1, 0, 32'h0);
        cyc("t4_issue", 1, 1, 0, 0, 0);
        bus(0, 0, 32'h0);
        flushM = 1'b1;
        cyc("t4_flush", 0, 1, 0, 0, 0);
        drive(1, 0, 32'h0000_4100, 32'h0, 0, 0);
        cyc("t4_drain", 0, 1, 0, 1, 32'hDEAD_BEEF);
        bus(0, 1, 32'hBAD0_BAD0);
        cyc("t4_orphan", 0, 1, 0, 1, 32'hDEAD_BEEF);
        exp_req.push_back('{1'b0, 32'h0000_4100, 32'h0});
        exp_rd.push_back(32'h600D_F00D);
        bus(1, 0, 32'h0);
        cyc("t4_reissue", 1, 1, 0, 1, 32'hDEAD_BEEF);
        bus(0, 1, 32'h600D_F00D);
        cyc("t4_data", 0, 0, 0, 1, 32'h600D_F00D);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        bus(0, 0, 32'h0);
        cyc("t4_after", 0, 0, 0, 1, 32'h600D_F00D);

        // data_ok while held -> DONE keeps the result, no second request
        exp_req.push_back('{1'b0, 32'h0000_5000, 32'h0});
        drive(1, 0, 32'h0000_5000, 32'h0, 0, 0);
        bus(1, 0, 32'h0);
        cyc("t5_issue", 1, 1, 0, 0, 0);
        holdM = 1'b1;
        bus(0, 1, 32'hCAFE_0001);
        cyc("t5_data", 0, 0, 0, 1, 32'hCAFE_0001);
        bus(0, 0, 32'h0);
        cyc("t5_hold1", 0, 0, 0, 1, 32'hCAFE_0001);
        cyc("t5_hold2", 0, 0, 0, 1, 32'hCAFE_0001);
        exp_rd.push_back(32'hCAFE_0001);
        holdM = 1'b0;
        cyc("t5_release", 0, 0, 0, 1, 32'hCAFE_0001);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        cyc("t5_idle", 0, 0, 0, 1, 32'hCAFE_0001);

        // Unaligned accesses and flush in IDLE
        drive(1, 0, 32'h0000_1002, 32'h0, 0, 0);
        cyc("t6_ld_unal", 0, 0, 1, 0, 0);
        drive(0, 1, 32'h0000_2003, 32'h0BAD_0BAD, 0, 0);
        cyc("t6_st_unal", 0, 0, 1, 0, 0);
        drive(1, 0, 32'h0000_1002, 32'h0, 1, 0);
        cyc("t6_unal_fl", 0, 0, 0, 0, 0);
        drive(1, 0, 32'h0000_3000, 32'h0, 1, 0);
        cyc("t6_idle_fl", 0, 0, 0, 1, 32'hCAFE_0001);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        cyc("t6_idle", 0, 0, 0, 0, 0);

        // Reset asserted while in WAIT
        exp_req.push_back('{1'b0, 32'h0000_7000, 32'h0});
        drive(1, 0, 32'h0000_7000, 32'h0, 0, 0);
        bus(1, 0, 32'h0);
        cyc("t7_issue", 1, 1, 0, 0, 0);
        bus(0, 0, 32'h0);
        cyc("t7_wait", 0, 1, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        cyc("t7_reset", 0, 0, 0, 1, 32'h0);
        reset = 1'b1;
        cyc("t7_idle", 0, 0, 0, 1, 32'h0);

        check("req_queue_empty", 32'(exp_req.size()), 32'd0);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
